progmem_fetch_master: RTL and testbench

Avalon-MM-style read initiator that streams sequential 32-bit words from the program ROM slave into a small prefetch FIFO. It exposes a valid/ready word stream to the DSI command sequencer. A redirect input restarts fetching from a new word address. One outstanding bus read at a time.

---
 rtl/progmem_fetch_master.sv | 149 ++++++++++++++
 tb/tb_progmem_fetch_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_fetch_master.sv
// Sequential program-word fetcher: single-outstanding Avalon-MM read master feeding a prefetch FIFO.
// Define PFETCH_ADDR_TAG_EN to store each word's address in the FIFO and expose fetch_addr.
module progmem_fetch_master #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [31:0]       fetch_data,
`ifdef PFETCH_ADDR_TAG_EN
  output logic [ADDR_W-1:0] fetch_addr,
`endif
  output logic              fetch_err,
  output logic [ADDR_W-1:0] mst_address,
  output logic              mst_read,
  input  logic [31:0]       mst_readdata,
  input  logic [1:0]        mst_response,
  input  logic              mst_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PFETCH_ADDR_TAG_EN
  localparam int ENTRY_W = 32 + ADDR_W;
`else
  localparam int ENTRY_W = 32;
`endif
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, READ} state_e;

  state_e              state_q;
  logic                mst_read_q;
  logic                err_q, err_d;
  logic                drop_q;
  logic [ADDR_W-1:0]   mst_addr_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic                complete, resp_ok, push, pop, issue_ok;

  assign complete = mst_read_q && !mst_waitrequest;
  assign resp_ok  = (mst_response == 2'b00);
  // Redirect flushes the FIFO, so it overrides both a landing word and a consumer pop.
  assign push     = complete && resp_ok && !drop_q && !redirect_valid;
  assign pop      = (count_q != '0) && fetch_ready && !redirect_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    if (redirect_valid) begin
      count_d = '0;
      ptr_d   = redirect_addr;
      err_d   = 1'b0;
    end else begin
      if (push && !pop) count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
      if (push) ptr_d = ptr_q + ADDR_W'(1);
      if (complete && !resp_ok && !drop_q) err_d = 1'b1;
    end
  end

  // Judged on post-edge occupancy: a word landing now already holds its slot.
  assign issue_ok = fetch_en && !err_d && (count_d < DEPTH_C);

  // NOTE: state registers use non-blocking assignments so each samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mst_read_q <= 1'b0;
      mst_addr_q <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_q    <= READ;
            mst_read_q <= 1'b1;
            mst_addr_q <= ptr_d;
          end
        end
        READ: begin
          if (complete) begin
            drop_q <= 1'b0;
            if (issue_ok) begin
              mst_addr_q <= ptr_d;
            end else begin
              state_q    <= IDLE;
              mst_read_q <= 1'b0;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef PFETCH_ADDR_TAG_EN
  assign push_entry = {mst_addr_q, mst_readdata};
`else
  assign push_entry = mst_readdata;
`endif

  // NOTE: storage has no reset; fetch_valid (from count_q) guards every stale entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry  = mem_q[rd_ptr_q];
  assign fetch_valid = (count_q != '0);
  assign fetch_data  = head_entry[31:0];
`ifdef PFETCH_ADDR_TAG_EN
  assign fetch_addr  = head_entry[32 +: ADDR_W];
`endif
  assign fetch_err   = err_q;
  assign mst_read    = mst_read_q;
  assign mst_address = mst_addr_q;

endmodule

// File: tb/tb_progmem_fetch_master.sv
// Directed bench for progmem_fetch_master: ROM slave model with programmable stalls and
// error injection, plus a consumer log; each step checks against hand-computed values.
module tb_progmem_fetch_master;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [31:0]       fetch_data;
`ifdef PFETCH_ADDR_TAG_EN
  logic [ADDR_W-1:0] fetch_addr;
`endif
  logic              fetch_err;
  logic [ADDR_W-1:0] mst_address;
  logic              mst_read;
  logic [31:0]       mst_readdata = '0;
  logic [1:0]        mst_response = '0;
  logic              mst_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  int wait_cnt = 0;
  logic              err_en = 1'b0;
  logic [ADDR_W-1:0] err_addr = '0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [31:0]       pop_log[$];

  progmem_fetch_master #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_data      (fetch_data),
`ifdef PFETCH_ADDR_TAG_EN
    .fetch_addr      (fetch_addr),
`endif
    .fetch_err       (fetch_err),
    .mst_address     (mst_address),
    .mst_read        (mst_read),
    .mst_readdata    (mst_readdata),
    .mst_response    (mst_response),
    .mst_waitrequest (mst_waitrequest)
  );

  always #5 clk = ~clk;

  // ROM slave: stalls each read stall_cycles cycles, then returns 0xA000_0000 + address.
  always @(negedge clk) begin
    if (!rst_n || !mst_read) begin
      mst_waitrequest = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt < stall_cycles) begin
      mst_waitrequest = 1'b1;
      wait_cnt++;
    end else begin
      mst_waitrequest = 1'b0;
      wait_cnt = 0;
      mst_readdata = 32'hA000_0000 + 32'(mst_address);
      mst_response = (err_en && mst_address == err_addr) ? 2'b10 : 2'b00;
      rd_log.push_back(mst_address);
    end
  end

  // Consumer log: words accepted at the coming edge.
  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready && !redirect_valid) pop_log.push_back(fetch_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [ADDR_W-1:0] rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 'x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(input logic [ADDR_W-1:0] a);
    redirect_addr  = a;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(pop_log.size() >= n), 64'd1);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    pop_log.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    fetch_ready    = 1'b0;
    steps(2);
    check("rst_mst_read",    64'(mst_read),    64'd0);
    check("rst_mst_address", 64'(mst_address), 64'd0);
    check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check("rst_fetch_err",   64'(fetch_err),   64'd0);

    // Sequential stream from address 0, one stall cycle per read.
    rst_n        = 1'b1;
    stall_cycles = 1;
    fetch_en     = 1'b1;
    fetch_ready  = 1'b1;
    wait_pops(6, 100, "s1_timeout");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_data%0d", i), 64'(pop_at(i)), 64'(32'hA000_0000 + i));
      check($sformatf("s1_addr%0d", i), 64'(rd_at(i)),  64'(i));
    end
    fetch_en = 1'b0;
    steps(10);
    check("s1_idle_read",  64'(mst_read),    64'd0);
    check("s1_idle_valid", 64'(fetch_valid), 64'd0);

    // Backpressure: four reads fill the FIFO, the fifth waits for a pop.
    clear_logs();
    stall_cycles = 0;
    fetch_ready  = 1'b0;
    fetch_en     = 1'b1;
    redirect_to(10'h010);
    steps(20);
    check("s2_reads_full", 64'(rd_log.size()), 64'd4);
    check("s2_read_off",   64'(mst_read),      64'd0);
    check("s2_valid",      64'(fetch_valid),   64'd1);
    check("s2_head",       64'(fetch_data),    64'hA000_0010);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    steps(10);
    check("s2_reads_after_pop", 64'(rd_log.size()),  64'd5);
    check("s2_fifth_addr",      64'(rd_at(4)),       64'h014);
    check("s2_pops",            64'(pop_log.size()), 64'd1);
    check("s2_head_after_pop",  64'(fetch_data),     64'hA000_0011);
    check("s2_read_off2",       64'(mst_read),       64'd0);
    fetch_en    = 1'b0;
    fetch_ready = 1'b1;
    steps(10);

    // Redirect during a stalled read of 5: the address holds, the word is dropped, then wrap.
    clear_logs();
    stall_cycles = 3;
    fetch_en     = 1'b1;
    redirect_to(10'h005);
    step();
    redirect_to(10'h3FE);
    check("s3_hold_read_a", 64'(mst_read),    64'd1);
    check("s3_hold_addr_a", 64'(mst_address), 64'h005);
    step();
    check("s3_hold_read_b", 64'(mst_read),    64'd1);
    check("s3_hold_addr_b", 64'(mst_address), 64'h005);
    wait_pops(3, 100, "s3_timeout");
    check("s3_rd0", 64'(rd_at(0)), 64'h005);
    check("s3_rd1", 64'(rd_at(1)), 64'h3FE);
    check("s3_rd2", 64'(rd_at(2)), 64'h3FF);
    check("s3_rd3", 64'(rd_at(3)), 64'h000);
    check("s3_pop0", 64'(pop_at(0)), 64'hA000_03FE);
    check("s3_pop1", 64'(pop_at(1)), 64'hA000_03FF);
    check("s3_pop2", 64'(pop_at(2)), 64'hA000_0000);
    fetch_en = 1'b0;
    steps(12);

    // Error response on address 7 stops fetching until a redirect clears it.
    clear_logs();
    stall_cycles = 0;
    err_addr     = 10'h007;
    err_en       = 1'b1;
    fetch_en     = 1'b1;
    redirect_to(10'h006);
    steps(8);
    check("s4_err",       64'(fetch_err),      64'd1);
    check("s4_read_off",  64'(mst_read),       64'd0);
    check("s4_reads",     64'(rd_log.size()),  64'd2);
    check("s4_pops",      64'(pop_log.size()), 64'd1);
    check("s4_pop0",      64'(pop_at(0)),      64'hA000_0006);
    err_en = 1'b0;
    redirect_to(10'h007);
    fetch_en = 1'b0;
    check("s4_err_clr",   64'(fetch_err),   64'd0);
    check("s4_reissue",   64'(mst_read),    64'd1);
    check("s4_reissue_a", 64'(mst_address), 64'h007);
    check("s4_lat_low",   64'(fetch_valid), 64'd0);
    step();
    check("s4_lat_high",  64'(fetch_valid), 64'd1);
    check("s4_lat_data",  64'(fetch_data),  64'hA000_0007);
`ifdef PFETCH_ADDR_TAG_EN
    check("s4_tag",       64'(fetch_addr),  64'h007);
`endif
    check("s4_stop",      64'(mst_read),    64'd0);
    steps(5);
    check("s4_pops2",     64'(pop_log.size()), 64'd2);
    check("s4_pop1",      64'(pop_at(1)),      64'hA000_0007);

    // fetch_en drops during a stalled read: that read lands, nothing more issues.
    clear_logs();
    stall_cycles = 3;
    fetch_en     = 1'b1;
    redirect_to(10'h020);
    step();
    fetch_en = 1'b0;
    steps(10);
    check("s5_reads",    64'(rd_log.size()),  64'd1);
    check("s5_read_off", 64'(mst_read),       64'd0);
    check("s5_pops",     64'(pop_log.size()), 64'd1);
    check("s5_pop0",     64'(pop_at(0)),      64'hA000_0020);
    clear_logs();
    fetch_en    = 1'b1;
    fetch_ready = 1'b0;
    step();
    check("s5_resume",   64'(mst_read),    64'd1);
    check("s5_resume_a", 64'(mst_address), 64'h021);

    // Async reset in the middle of the read of 0x022 with one word buffered.
    steps(5);
    check("s6_pre_read",  64'(mst_read),    64'd1);
    check("s6_pre_addr",  64'(mst_address), 64'h022);
    check("s6_pre_valid", 64'(fetch_valid), 64'd1);
    check("s6_pre_data",  64'(fetch_data),  64'hA000_0021);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_read",  64'(mst_read),    64'd0);
    check("s6_rst_valid", 64'(fetch_valid), 64'd0);
    check("s6_rst_err",   64'(fetch_err),   64'd0);
    check("s6_rst_addr",  64'(mst_address), 64'd0);
    steps(2);
    clear_logs();
    rst_n       = 1'b1;
    fetch_ready = 1'b1;
    step();
    check("s6_restart",   64'(mst_read),    64'd1);
    check("s6_restart_a", 64'(mst_address), 64'd0);
    wait_pops(2, 100, "s6_timeout");
    check("s6_pop0", 64'(pop_at(0)), 64'hA000_0000);
    check("s6_pop1", 64'(pop_at(1)), 64'hA000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
